dsp_addsub_acc: RTL and testbench

DSP_ADDSUB_ACC -- requirements
Module: dsp_addsub_acc

---
 rtl/dsp_addsub_acc.sv | 173 +++++++++++++++++
 tb/tb_dsp_addsub_acc.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_addsub_acc.sv
// dsp_addsub_acc: pipelined signed add/subtract unit with an internal accumulator.
//
// Ports:
//   clock      - sole clock; every state update happens on its rising edge
//   reset      - synchronous, active-high; clears outputs, accumulator and pipeline
//   in_valid   - qualifies op/a/b/clear for an arithmetic operation this cycle
//   op[1:0]    - 00 ADD (a+b), 01 SUB (a-b), 10 ACC_ADD (acc+a), 11 ACC_SUB (acc-a)
//   clear      - zeroes the accumulator whether or not in_valid is high
//   a, b       - WIDTH-bit two's complement operands (b unused by ACC ops)
//   y          - WIDTH-bit wrapped result, LATENCY cycles after acceptance
//   ovf        - signed overflow of the exact result, aligned with y
//   out_valid  - high for exactly the cycles on which y/ovf carry a new result
//
// The arithmetic and the accumulator update both live in the first stage, so
// back-to-back ACC ops always see the accumulator written by the previous op.
// The remaining LATENCY-1 stages only delay the result. y/ovf hold their last
// value whenever no result arrives.
module dsp_addsub_acc #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             ovf,
  output logic             out_valid
);

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_ACC_ADD = 2'b10;
  localparam logic [1:0] OP_ACC_SUB = 2'b11;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH:0]   ext_a, ext_b, ext_base, exact;
  logic [WIDTH-1:0] res_y;
  logic             res_ovf;
  logic             res_vld;

  // Signals entering the output register (from stage 1 or the delay line).
  logic [WIDTH-1:0] fin_y;
  logic             fin_ovf;
  logic             fin_vld;

  logic [WIDTH-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  // Stage-1 arithmetic and accumulator next value.
  always_comb begin
    // clear in the same cycle as an ACC op makes that op start from zero.
    if (clear) begin
      acc_base = {WIDTH{1'b0}};
    end else begin
      acc_base = acc_q;
    end
    // One extra sign bit makes the sum exact, so overflow is just a
    // disagreement between the top two bits.
    ext_a    = {a[WIDTH-1], a};
    ext_b    = {b[WIDTH-1], b};
    ext_base = {acc_base[WIDTH-1], acc_base};
    case (op)
      OP_ADD:     exact = ext_a + ext_b;
      OP_SUB:     exact = ext_a - ext_b;
      OP_ACC_ADD: exact = ext_base + ext_a;
      OP_ACC_SUB: exact = ext_base - ext_a;
      default:    exact = ext_a + ext_b;
    endcase
    res_y   = exact[WIDTH-1:0];
    res_ovf = exact[WIDTH] ^ exact[WIDTH-1];
    res_vld = in_valid;

    // ADD/SUB leave the accumulator alone except for a concurrent clear.
    if (in_valid && op[1]) begin
      acc_d = res_y;
    end else if (clear) begin
      acc_d = {WIDTH{1'b0}};
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= {WIDTH{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign fin_y   = res_y;
      assign fin_ovf = res_ovf;
      assign fin_vld = res_vld;
    end else begin : g_pipe
      logic [WIDTH-1:0]   dly_y_q   [LATENCY-1];
      logic [WIDTH-1:0]   dly_y_d   [LATENCY-1];
      logic [LATENCY-2:0] dly_ovf_q, dly_ovf_d;
      logic [LATENCY-2:0] dly_vld_q, dly_vld_d;

      // Shift the stage-1 result down the delay line.
      always_comb begin
        dly_y_d[0]   = res_y;
        dly_ovf_d[0] = res_ovf;
        dly_vld_d[0] = res_vld;
        for (int i = 1; i < LATENCY - 1; i++) begin
          dly_y_d[i]   = dly_y_q[i-1];
          dly_ovf_d[i] = dly_ovf_q[i-1];
          dly_vld_d[i] = dly_vld_q[i-1];
        end
      end

      // Delay-line registers; reset drops every in-flight result.
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < LATENCY - 1; i++) begin
            dly_y_q[i] <= {WIDTH{1'b0}};
          end
          dly_ovf_q <= {(LATENCY-1){1'b0}};
          dly_vld_q <= {(LATENCY-1){1'b0}};
        end else begin
          for (int i = 0; i < LATENCY - 1; i++) begin
            dly_y_q[i] <= dly_y_d[i];
          end
          dly_ovf_q <= dly_ovf_d;
          dly_vld_q <= dly_vld_d;
        end
      end

      assign fin_y   = dly_y_q[LATENCY-2];
      assign fin_ovf = dly_ovf_q[LATENCY-2];
      assign fin_vld = dly_vld_q[LATENCY-2];
    end
  endgenerate

  // Output register next values: y/ovf hold when no result arrives.
  always_comb begin
    out_valid_d = fin_vld;
    if (fin_vld) begin
      y_d   = fin_y;
      ovf_d = fin_ovf;
    end else begin
      y_d   = y_q;
      ovf_d = ovf_q;
    end
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      y_q         <= {WIDTH{1'b0}};
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dsp_addsub_acc.sv
// Self-checking bench for dsp_addsub_acc. Four instances run side by side on
// the same stimulus: (W8,L2), (W8,L1), (W8,L4), (W16,L2). A scheduled-result
// model computes each expected output with plain signed integer arithmetic.
module tb_dsp_addsub_acc;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        clear;
  logic [1:0]  op;
  logic [15:0] a16, b16;

  logic [7:0]  y0, y1, y2;
  logic [15:0] y3;
  logic        ovf0, ovf1, ovf2, ovf3;
  logic        ov0, ov1, ov2, ov3;

  int n_vec = 0;
  int n_bad = 0;

  int cfg_w [4] = '{8, 8, 8, 16};
  int cfg_l [4] = '{2, 1, 4, 2};

  longint acc_m  [4];
  bit     ring_v [4][8];
  longint ring_y [4][8];
  bit     ring_o [4][8];
  bit     exp_v  [4];
  longint exp_y  [4];
  bit     exp_o  [4];
  int     edge_n = 0;

  always #5 clock = ~clock;

  dsp_addsub_acc #(.WIDTH(8), .LATENCY(2)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .op(op), .clear(clear),
    .a(a16[7:0]), .b(b16[7:0]), .y(y0), .ovf(ovf0), .out_valid(ov0));
  dsp_addsub_acc #(.WIDTH(8), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .op(op), .clear(clear),
    .a(a16[7:0]), .b(b16[7:0]), .y(y1), .ovf(ovf1), .out_valid(ov1));
  dsp_addsub_acc #(.WIDTH(8), .LATENCY(4)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .op(op), .clear(clear),
    .a(a16[7:0]), .b(b16[7:0]), .y(y2), .ovf(ovf2), .out_valid(ov2));
  dsp_addsub_acc #(.WIDTH(16), .LATENCY(2)) dut3 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .op(op), .clear(clear),
    .a(a16), .b(b16), .y(y3), .ovf(ovf3), .out_valid(ov3));

  // Signed value of the low w bits of v.
  function automatic longint sval(longint v, int w);
    longint x;
    x = v & ((longint'(1) << w) - 1);
    if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
    return x;
  endfunction

  // Advance the model by one rising edge using the inputs just sampled.
  task automatic model_edge();
    for (int k = 0; k < 4; k++) begin
      int     w;
      int     slot;
      longint sa, sb, base, ex, hi, lo, yw;
      bit     ov;
      w = cfg_w[k];
      if (reset) begin
        acc_m[k] = 0;
        for (int s = 0; s < 8; s++) ring_v[k][s] = 1'b0;
        exp_v[k] = 1'b0;
        exp_y[k] = 0;
        exp_o[k] = 1'b0;
      end else begin
        sa   = sval(longint'(a16), w);
        sb   = sval(longint'(b16), w);
        base = clear ? 0 : acc_m[k];
        case (op)
          2'd0:    ex = sa + sb;
          2'd1:    ex = sa - sb;
          2'd2:    ex = base + sa;
          default: ex = base - sa;
        endcase
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        ov = (ex > hi) || (ex < lo);
        yw = ex & ((longint'(1) << w) - 1);
        if (clear) acc_m[k] = 0;
        if (in_valid && op >= 2'd2) acc_m[k] = sval(yw, w);
        if (in_valid) begin
          slot = (edge_n + cfg_l[k] - 1) % 8;
          ring_v[k][slot] = 1'b1;
          ring_y[k][slot] = yw;
          ring_o[k][slot] = ov;
        end
        slot = edge_n % 8;
        if (ring_v[k][slot]) begin
          exp_v[k] = 1'b1;
          exp_y[k] = ring_y[k][slot];
          exp_o[k] = ring_o[k][slot];
          ring_v[k][slot] = 1'b0;
        end else begin
          exp_v[k] = 1'b0;
        end
      end
    end
    edge_n++;
  endtask

  task automatic get_dut(input int k, output logic dv, output logic [63:0] dy, output logic dov);
    case (k)
      0:       begin dv = ov0; dy = {56'd0, y0}; dov = ovf0; end
      1:       begin dv = ov1; dy = {56'd0, y1}; dov = ovf1; end
      2:       begin dv = ov2; dy = {56'd0, y2}; dov = ovf2; end
      default: begin dv = ov3; dy = {48'd0, y3}; dov = ovf3; end
    endcase
  endtask

  task automatic check(input string nm, input int k, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s inst%0d edge %0d: got 0x%0h expected 0x%0h", nm, k, edge_n, got, want);
    end
  endtask

  // Compare every instance against the model.
  task automatic compare_all();
    logic        dv, dov;
    logic [63:0] dy;
    for (int k = 0; k < 4; k++) begin
      get_dut(k, dv, dy, dov);
      check("out_valid", k, {63'd0, dv}, {63'd0, exp_v[k]});
      check("y", k, dy, exp_y[k]);
      check("ovf", k, {63'd0, dov}, {63'd0, exp_o[k]});
    end
  endtask

  // Hand-computed expectation: pins both the DUT and the model.
  task automatic lit(input int k, input bit v, input longint yv, input bit o);
    logic        dv, dov;
    logic [63:0] dy;
    get_dut(k, dv, dy, dov);
    check("lit_out_valid", k, {63'd0, dv}, {63'd0, v});
    check("lit_y", k, dy, yv);
    check("lit_ovf", k, {63'd0, dov}, {63'd0, o});
    check("model_y", k, exp_y[k], yv);
    check("model_valid", k, {63'd0, exp_v[k]}, {63'd0, v});
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  task automatic drv(input bit r, input bit v, input logic [1:0] o, input logic [15:0] aa,
                     input logic [15:0] bb, input bit c);
    reset = r; in_valid = v; op = o; a16 = aa; b16 = bb; clear = c;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0);
  endtask

  initial begin
    // Reset first so every compare starts from defined outputs.
    drv(1'b1, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0);
    step();
    step();
    lit(0, 1'b0, 0, 1'b0);

    // SUB 8-33 across all latencies/widths.
    drv(1'b0, 1'b1, 2'd1, 16'd8, 16'd33, 1'b0);
    step();
    lit(1, 1'b1, 64'hE7, 1'b0);
    idle();
    step();
    lit(0, 1'b1, 64'hE7, 1'b0);
    lit(3, 1'b1, 64'hFFE7, 1'b0);
    lit(1, 1'b0, 64'hE7, 1'b0);
    step();
    lit(0, 1'b0, 64'hE7, 1'b0);
    step();
    lit(2, 1'b1, 64'hE7, 1'b0);

    // ADD 100+100, then SUB -128-1, back to back.
    drv(1'b0, 1'b1, 2'd0, 16'd100, 16'd100, 1'b0);
    step();
    drv(1'b0, 1'b1, 2'd1, 16'hFF80, 16'd1, 1'b0);
    step();
    lit(0, 1'b1, 64'hC8, 1'b1);
    idle();
    step();
    lit(0, 1'b1, 64'h7F, 1'b1);

    // clear, ACC_ADD 5, ACC_ADD 7, ADD 1+1, ACC_SUB 20.
    drv(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b1);
    step();
    drv(1'b0, 1'b1, 2'd2, 16'd5, 16'd0, 1'b0);
    step();
    drv(1'b0, 1'b1, 2'd2, 16'd7, 16'd0, 1'b0);
    step();
    lit(0, 1'b1, 64'd5, 1'b0);
    drv(1'b0, 1'b1, 2'd0, 16'd1, 16'd1, 1'b0);
    step();
    lit(0, 1'b1, 64'd12, 1'b0);
    drv(1'b0, 1'b1, 2'd3, 16'd20, 16'd0, 1'b0);
    step();
    lit(0, 1'b1, 64'd2, 1'b0);
    lit(1, 1'b1, 64'hF8, 1'b0);
    idle();
    step();
    lit(0, 1'b1, 64'hF8, 1'b0);
    lit(3, 1'b1, 64'hFFF8, 1'b0);
    step();
    step();
    lit(2, 1'b1, 64'hF8, 1'b0);

    // acc=120, then ACC_ADD 10 with clear, then ACC_ADD 0.
    drv(1'b0, 1'b1, 2'd2, 16'd120, 16'd0, 1'b1);
    step();
    drv(1'b0, 1'b1, 2'd2, 16'd10, 16'd0, 1'b1);
    step();
    lit(0, 1'b1, 64'd120, 1'b0);
    drv(1'b0, 1'b1, 2'd2, 16'd0, 16'd0, 1'b0);
    step();
    lit(0, 1'b1, 64'd10, 1'b0);
    idle();
    step();
    lit(0, 1'b1, 64'd10, 1'b0);

    // Reset in the middle of traffic drops in-flight results and the acc.
    drv(1'b0, 1'b1, 2'd0, 16'd1, 16'd2, 1'b0);
    step();
    drv(1'b0, 1'b1, 2'd0, 16'd3, 16'd4, 1'b0);
    step();
    lit(0, 1'b1, 64'd3, 1'b0);
    drv(1'b1, 1'b1, 2'd0, 16'd5, 16'd6, 1'b0);
    step();
    lit(0, 1'b0, 64'd0, 1'b0);
    idle();
    step();
    lit(0, 1'b0, 64'd0, 1'b0);
    drv(1'b0, 1'b1, 2'd2, 16'd3, 16'd0, 1'b0);
    step();
    lit(0, 1'b0, 64'd0, 1'b0);
    idle();
    step();
    lit(0, 1'b1, 64'd3, 1'b0);
    step();
    lit(0, 1'b0, 64'd3, 1'b0);

    // Randomized traffic with occasional reset/clear and boundary operands.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       ra = 16'h007F;
        1:       ra = 16'hFF80;
        2:       ra = 16'h7FFF;
        3:       ra = 16'h8000;
        default: ra = ra;
      endcase
      if ($urandom_range(0, 5) == 0) rb = 16'hFFFF;
      drv($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
          ra, rb, $urandom_range(0, 9) == 0);
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
